// File: rtl/branch_resolve_tracker.sv
// Execute-side tracker for decode-time conditional-branch predictions.
// Queues predictions in order, checks them at resolve, and drives predictor feedback and mispredict redirects.
module branch_resolve_tracker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_prediction,
  input  logic [ADDR_WIDTH-1:0] dec_recovery_target,
  output logic                  dec_ready,
  input  logic                  ex_valid,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_outcome,
  output logic                  fb_valid,
  output logic [ADDR_WIDTH-1:0] fb_pc,
  output logic                  fb_prediction,
  output logic                  fb_outcome,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  err,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] tgt_mem  [DEPTH];
  logic [PW-1:0]         head_r;
  logic [PW-1:0]         tail_r;
  logic [CW-1:0]         count_r;

  logic push_s;
  logic pop_s;
  logic mis_s;
  logic pc_bad_s;

  assign dec_ready = (count_r != CW'(DEPTH));

  // Decode the push/pop handshakes and compare the resolved head against its record.
  always_comb begin
    push_s   = dec_valid & dec_ready;
    pop_s    = ex_valid & (count_r != {CW{1'b0}});
    mis_s    = 1'b0;
    pc_bad_s = 1'b0;
    if (pop_s) begin
      mis_s    = (ex_outcome != pred_mem[head_r]);
      pc_bad_s = (ex_pc != pc_mem[head_r]);
    end else begin
      mis_s    = 1'b0;
      pc_bad_s = 1'b0;
    end
  end

  // Queue state, registered feedback/redirect outputs, sticky error and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= {ADDR_WIDTH{1'b0}};
        pred_mem[i] <= 1'b0;
        tgt_mem[i]  <= {ADDR_WIDTH{1'b0}};
      end
      head_r           <= {PW{1'b0}};
      tail_r           <= {PW{1'b0}};
      count_r          <= {CW{1'b0}};
      fb_valid         <= 1'b0;
      fb_pc            <= {ADDR_WIDTH{1'b0}};
      fb_prediction    <= 1'b0;
      fb_outcome       <= 1'b0;
      mispredict       <= 1'b0;
      redirect_pc      <= {ADDR_WIDTH{1'b0}};
      err              <= 1'b0;
      stat_branches    <= {STAT_WIDTH{1'b0}};
      stat_mispredicts <= {STAT_WIDTH{1'b0}};
    end else begin
      fb_valid   <= pop_s;
      mispredict <= mis_s;
      if (pop_s) begin
        fb_pc         <= pc_mem[head_r];
        fb_prediction <= pred_mem[head_r];
        fb_outcome    <= ex_outcome;
      end
      if (mis_s) begin
        redirect_pc <= tgt_mem[head_r];
      end
      if ((ex_valid && (count_r == {CW{1'b0}})) || pc_bad_s) begin
        err <= 1'b1;
      end
      if (pop_s && (stat_branches != STAT_MAX)) begin
        stat_branches <= stat_branches + STAT_WIDTH'(1);
      end
      if (mis_s && (stat_mispredicts != STAT_MAX)) begin
        stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      end
      // A mispredict discards all younger entries, including a same-cycle wrong-path push.
      if (mis_s) begin
        count_r <= {CW{1'b0}};
        head_r  <= tail_r;
      end else begin
        if (push_s) begin
          pc_mem[tail_r]   <= dec_pc;
          pred_mem[tail_r] <= dec_prediction;
          tgt_mem[tail_r]  <= dec_recovery_target;
          tail_r           <= tail_r + PW'(1);
        end
        if (pop_s) begin
          head_r <= head_r + PW'(1);
        end
        count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
    end
  end

endmodule
